// File: rtl/ifetch_pkg.sv
// rtl/ifetch_pkg.sv - shared FSM encoding and constants for the instruction-fetch block
package ifetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } fetch_state_t;

  localparam int INSTR_BYTES = 4;

endpackage

// File: rtl/ifetch_fifo.sv
// rtl/ifetch_fifo.sv - synchronous prefetch FIFO of {pc,instr} entries
// flush overrides push and pop; head reads as zero while empty.
module ifetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;

  assign full  = (count == (PW+1)'(DEPTH));
  assign empty = (count == '0);
  assign head  = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  // Storage needs no reset: entries are only visible through count.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/ifetch_ctrl.sv
// rtl/ifetch_ctrl.sv - fetch PC, run/halt FSM, redirect flush and decode handshake
// Reads a combinational ROM and buffers words in ifetch_fifo ahead of decode.
module ifetch_ctrl
  import ifetch_pkg::*;
#(
  parameter int                  ADDR_WIDTH = 32,
  parameter int                  DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
  parameter int                  FIFO_DEPTH = 2,
  parameter int                  CNT_WIDTH  = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  output logic [ADDR_WIDTH-1:0] o_rom_addr,
  input  logic [DATA_WIDTH-1:0] i_rom_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_instr,
  output logic [ADDR_WIDTH-1:0] o_pc,
  input  logic                  i_halt,
  input  logic                  i_redirect,
  input  logic [ADDR_WIDTH-1:0] i_redirect_pc,
  output logic                  o_misalign,
  output logic [CNT_WIDTH-1:0]  o_instr_cnt
);

  fetch_state_t state, state_nxt;
  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [ADDR_WIDTH+DATA_WIDTH-1:0] fifo_head;
  logic                  pop;
  logic                  push;

  assign o_rom_addr = fetch_pc;
  assign o_valid    = !fifo_empty;
  assign o_pc       = fifo_head[ADDR_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
  assign o_instr    = fifo_head[DATA_WIDTH-1:0];

  always_comb begin
    state_nxt = state;
    pop       = o_valid && i_ready;
    push      = 1'b0;
    case (state)
      S_IDLE: state_nxt = S_RUN;
      S_RUN: begin
        // A full FIFO still accepts a word when the head leaves this cycle.
        push = !i_redirect && (!fifo_full || pop);
        if (i_halt) state_nxt = S_HALT;
      end
      S_HALT: if (!i_halt) state_nxt = S_RUN;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= S_IDLE;
      fetch_pc    <= RESET_PC;
      o_misalign  <= 1'b0;
      o_instr_cnt <= '0;
    end else begin
      state      <= state_nxt;
      o_misalign <= i_redirect && (i_redirect_pc[1:0] != 2'b00);
      if (i_redirect) begin
        fetch_pc <= {i_redirect_pc[ADDR_WIDTH-1:2], 2'b00};
      end else begin
        if (push) fetch_pc <= fetch_pc + ADDR_WIDTH'(INSTR_BYTES);
        if (pop)  o_instr_cnt <= o_instr_cnt + CNT_WIDTH'(1);
      end
    end
  end

  ifetch_fifo #(
    .WIDTH (ADDR_WIDTH + DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .push  (push),
    .pop   (pop && !i_redirect),
    .flush (i_redirect),
    .wdata ({fetch_pc, i_rom_data}),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

endmodule

// File: tb/tb_ifetch_ctrl.sv
// tb/tb_ifetch_ctrl.sv - directed and randomized bench for ifetch_ctrl against a queue model
module tb_ifetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        valid;
  logic        ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        halt;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        misalign;
  logic [31:0] instr_cnt;

  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  bit          m_started;
  bit          m_fetch_en;
  bit          m_mis;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  assign rom_data = rom(rom_addr);

  ifetch_ctrl dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .o_rom_addr    (rom_addr),
    .i_rom_data    (rom_data),
    .o_valid       (valid),
    .i_ready       (ready),
    .o_instr       (instr),
    .o_pc          (pc),
    .i_halt        (halt),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc),
    .o_misalign    (misalign),
    .o_instr_cnt   (instr_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    assert (got === exp) pass_cnt++;
    else $error("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic model_reset();
    q.delete();
    m_pc       = 32'h0;
    m_cnt      = 32'h0;
    m_started  = 0;
    m_fetch_en = 0;
    m_mis      = 0;
  endtask

  // One clock edge of the intended behaviour, from the inputs held at that edge.
  task automatic model_edge();
    bit do_pop, do_push;
    do_pop  = (q.size() != 0) && ready;
    do_push = m_fetch_en && !redirect && (q.size() < 2 || do_pop);
    m_mis   = redirect && (redirect_pc[1:0] != 2'b00);
    if (redirect) begin
      q.delete();
      m_pc = redirect_pc & 32'hFFFF_FFFC;
    end else begin
      if (do_pop) begin
        void'(q.pop_front());
        m_cnt++;
      end
      if (do_push) begin
        q.push_back('{pc: m_pc, instr: rom(m_pc)});
        m_pc += 4;
      end
    end
    if (!m_started) begin
      m_started  = 1;
      m_fetch_en = 1;
    end else begin
      m_fetch_en = !halt;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"},    {31'b0, valid},    {31'b0, q.size() != 0});
    chk({tag, ".pc"},       pc,                (q.size() != 0) ? q[0].pc : 32'h0);
    chk({tag, ".instr"},    instr,             (q.size() != 0) ? q[0].instr : 32'h0);
    chk({tag, ".rom_addr"}, rom_addr,          m_pc);
    chk({tag, ".misalign"}, {31'b0, misalign}, {31'b0, m_mis});
    chk({tag, ".cnt"},      instr_cnt,         m_cnt);
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    rst_n = 1'b0;
    ready = 1'b1;
    halt = 1'b0;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    model_reset();
    #3;
    check_all("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Streaming from reset.
    for (int i = 0; i < 5; i++) cycle("t1");
    chk("t1.cnt3", instr_cnt, 32'd3);

    // Decode stalls, FIFO fills, head held.
    ready = 1'b0;
    for (int i = 0; i < 5; i++) cycle("t2.stall");
    ready = 1'b1;
    for (int i = 0; i < 3; i++) cycle("t2.drain");

    // Redirect while full.
    ready = 1'b0;
    for (int i = 0; i < 2; i++) cycle("t3.fill");
    redirect = 1'b1;
    redirect_pc = 32'h100;
    ready = 1'b1;
    cycle("t3.redir");
    redirect = 1'b0;
    chk("t3.valid_low", {31'b0, valid}, 32'd0);
    cycle("t3.first");
    chk("t3.pc100", pc, 32'h100);
    cycle("t3.next");

    // Misaligned redirect.
    redirect = 1'b1;
    redirect_pc = 32'h103;
    cycle("t4.redir");
    redirect = 1'b0;
    chk("t4.mis_pulse", {31'b0, misalign}, 32'd1);
    cycle("t4.first");
    chk("t4.mis_clear", {31'b0, misalign}, 32'd0);
    chk("t4.pc100", pc, 32'h100);

    // Halt drains the buffer; redirect under halt does not fetch.
    ready = 1'b0;
    for (int i = 0; i < 2; i++) cycle("t5.fill");
    halt = 1'b1;
    cycle("t5.halt");
    ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle("t5.drain");
    chk("t5.empty", {31'b0, valid}, 32'd0);
    redirect = 1'b1;
    redirect_pc = 32'h40;
    cycle("t5.redir");
    redirect = 1'b0;
    for (int i = 0; i < 2; i++) cycle("t5.held");
    chk("t5.nopush", {31'b0, valid}, 32'd0);
    halt = 1'b0;
    cycle("t5.resume");
    cycle("t5.first");
    chk("t5.pc40", pc, 32'h40);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      ready       = ($urandom % 4) != 0;
      if (($urandom % 10) == 0) halt = ~halt;
      redirect    = ($urandom % 12) == 0;
      redirect_pc = $urandom & 32'h0000_0FFF;
      cycle("rand");
    end
    halt = 1'b0;
    redirect = 1'b0;
    ready = 1'b1;
    for (int i = 0; i < 3; i++) cycle("settle");

    // Asynchronous reset mid-stream.
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("t6.rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cycle("t6.restart");

    // PC wrap at the top of the address space.
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    cycle("t6.redir");
    redirect = 1'b0;
    cycle("t6.top");
    chk("t6.pc_top", pc, 32'hFFFF_FFFC);
    cycle("t6.wrap");
    chk("t6.pc_wrap", pc, 32'h0);
    for (int i = 0; i < 3; i++) cycle("t6.after");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
